// File: rtl/sub_arbiter_if.sv
// Requester/response bundle for sub_arbiter: per-requester request levels and
// operands, one-hot grant pulses, the tagged valid/ready response, and busy.
interface sub_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] m_in;
    logic [4*NREQ-1:0] n_in;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [4:0]        rsp_z;
    logic              busy;

    // Response handshake: a transfer happens on every rising edge where
    // rsp_valid && rsp_ready; while rsp_valid is high and rsp_ready is low the
    // producer holds rsp_id/rsp_z stable, and rsp_valid never drops without a transfer.
    modport master (
        output req, m_in, n_in, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_z, busy
    );

    modport slave (
        input  req, m_in, n_in, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_z, busy
    );
endinterface

// File: rtl/sub_arbiter.sv
// Shares one registered 4-bit subtractor among NREQ requesters, one operation in flight.
// Define SUB_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module sub_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              sclk,
    input  logic              srst,
    sub_arbiter_if.slave      bus,
    output logic              sub_srst,
    output logic [3:0]        sub_m,
    output logic [3:0]        sub_n,
    input  logic [4:0]        sub_z,
    output logic [1:0]        dbg_state
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            take;
    logic            done;
    logic [NREQ-1:0] gnt_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [4:0]      rsp_z_q;
    logic [3:0]      m_arr [NREQ];
    logic [3:0]      n_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign m_arr[g] = bus.m_in[4*g +: 4];
        assign n_arr[g] = bus.n_in[4*g +: 4];
    end

    // Search upward from ptr with wrap; ptr stays 0 in the fixed-priority build.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign take = (state == IDLE) && found && !sub_srst;
    assign done = (state == RESP) && rsp_valid_q && bus.rsp_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = EXEC;
            EXEC:    state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sub_srst holds the datapath reset through the first edge after release.
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            sub_srst    <= 1'b1;
            ptr         <= '0;
            gnt_q       <= '0;
            sub_m       <= '0;
            sub_n       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
        end else begin
            sub_srst <= 1'b0;
            gnt_q    <= '0;
            if (take) begin
                sub_m    <= m_arr[win];
                sub_n    <= n_arr[win];
                gnt_q    <= NREQ'(1) << win;
                rsp_id_q <= win;
            end
            if (state == CAPT) begin
                rsp_z_q     <= sub_z;
                rsp_valid_q <= 1'b1;
            end
            if (done) begin
                rsp_valid_q <= 1'b0;
`ifdef SUB_ARB_RR_EN
                ptr <= (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
`else
                ptr <= '0;
`endif
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;
endmodule
